// File: rtl/weight_fifo_fill_ctrl_pkg.sv
// rtl/weight_fifo_fill_ctrl_pkg.sv - shared widths, FSM state and read latency for the weight FIFO fill controller
package weight_fifo_fill_ctrl_pkg;
   localparam int DEF_ROWS = 16;
   localparam int DEF_COLS = 16;
   localparam int RW       = $clog2(DEF_ROWS);
   localparam int CW       = $clog2(DEF_COLS);
   localparam int RD_LAT   = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } fill_state_t;
endpackage

// File: rtl/weight_fifo_en_gen.sv
// rtl/weight_fifo_en_gen.sv - read-latency delay, per-column stagger of FIFO enables and end-of-fill detection
module weight_fifo_en_gen
   import weight_fifo_fill_ctrl_pkg::*;
#(
   parameter int SYS_ARR_COLS = DEF_COLS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    active,
   input  logic                    stagger_load,
   output logic                    fifo_active,
   output logic [SYS_ARR_COLS-1:0] fifo_en,
   output logic                    drained
);
   localparam logic [RD_LAT-1:0]       LAST_LAT = RD_LAT'(1) << (RD_LAT - 1);
   localparam logic [SYS_ARR_COLS-2:0] LAST_SR  = (SYS_ARR_COLS - 1)'(1) << (SYS_ARR_COLS - 2);

   logic [RD_LAT-1:0]       act_pipe;
   logic [SYS_ARR_COLS-2:0] stagger_sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         act_pipe   <= '0;
         stagger_sr <= '0;
      end else begin
         act_pipe   <= (act_pipe << 1) | RD_LAT'(active);
         // Only shift in stagger mode so an unstaggered fill leaves nothing behind
         stagger_sr <= (stagger_sr << 1) | (SYS_ARR_COLS - 1)'(fifo_active && stagger_load);
      end
   end

   assign fifo_active = |(act_pipe & LAST_LAT);
   assign fifo_en     = stagger_load ? {stagger_sr, fifo_active} : {SYS_ARR_COLS{fifo_active}};

   // True in the final cycle any enable is visible: only the last stage may still hold data
   assign drained = !active && ((act_pipe & ~LAST_LAT) == '0) &&
                    (!stagger_load || (!fifo_active && ((stagger_sr & ~LAST_SR) == '0)));
endmodule

// File: rtl/weight_fifo_fill_ctrl.sv
// rtl/weight_fifo_fill_ctrl.sv - sequences one weight-tile load from banked weight memory into column FIFOs
module weight_fifo_fill_ctrl
   import weight_fifo_fill_ctrl_pkg::*;
#(
   parameter int SYS_ARR_ROWS = DEF_ROWS,
   parameter int SYS_ARR_COLS = DEF_COLS,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               stagger_load,
   input  logic [$clog2(SYS_ARR_ROWS)-1:0]    num_row,
   input  logic [$clog2(SYS_ARR_COLS)-1:0]    num_col,
   input  logic [ADDR_WIDTH-1:0]              base_addr,
   output logic [SYS_ARR_COLS-1:0]            weightMem_rd_en,
   output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] weightMem_rd_addr,
   output logic                               fifo_active,
   output logic [SYS_ARR_COLS-1:0]            fifo_en,
   output logic                               done
);
   localparam int ROW_W = $clog2(SYS_ARR_ROWS);
   localparam int COL_W = $clog2(SYS_ARR_COLS);

   fill_state_t state, next_state;
   logic [ROW_W-1:0]                   k, k_d, nrow_q;
   logic [COL_W-1:0]                   ncol_q, ncol_d;
   logic [ADDR_WIDTH-1:0]              base_q, base_d;
   logic                               stagger_q, accept, drained, done_d;
   logic [SYS_ARR_COLS-1:0]            rd_en_d;
   logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] rd_addr_d;

   // A start coinciding with done is dropped so the caller sees one clean idle cycle
   assign accept = (state == IDLE) && start && !done;
   assign k_d    = accept ? '0 : (state == READ) ? k + 1'b1 : k;
   assign ncol_d = accept ? num_col : ncol_q;
   assign base_d = accept ? base_addr : base_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         nrow_q    <= '0;
         ncol_q    <= '0;
         base_q    <= '0;
         stagger_q <= 1'b0;
      end else begin
         state <= next_state;
         k     <= k_d;
         if (accept) begin
            nrow_q    <= num_row;
            ncol_q    <= num_col;
            base_q    <= base_addr;
            stagger_q <= stagger_load;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = READ;
         READ:    if (k == nrow_q) next_state = DRAIN;
         DRAIN:   if (drained) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Read outputs are precomputed from the next state so the registered copies line up with READ
   always_comb begin
      rd_en_d   = '0;
      rd_addr_d = '0;
      if (next_state == READ) begin
         for (int c = 0; c < SYS_ARR_COLS; c++) begin
            if (c <= int'(ncol_d)) begin
               rd_en_d[c]                             = 1'b1;
               rd_addr_d[c*ADDR_WIDTH +: ADDR_WIDTH] = base_d + ADDR_WIDTH'(k_d);
            end
         end
      end
      done_d = (state == DRAIN) && drained;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         weightMem_rd_en   <= '0;
         weightMem_rd_addr <= '0;
         done              <= 1'b0;
      end else begin
         weightMem_rd_en   <= rd_en_d;
         weightMem_rd_addr <= rd_addr_d;
         done              <= done_d;
      end
   end

   weight_fifo_en_gen #(
      .SYS_ARR_COLS (SYS_ARR_COLS)
   ) u_en_gen (
      .clk          (clk),
      .reset        (reset),
      .active       (|weightMem_rd_en),
      .stagger_load (stagger_q),
      .fifo_active  (fifo_active),
      .fifo_en      (fifo_en),
      .drained      (drained)
   );
endmodule

// File: tb/tb_weight_fifo_fill_ctrl.sv
// tb/tb_weight_fifo_fill_ctrl.sv - self-checking bench for the weight FIFO fill controller
module tb_weight_fifo_fill_ctrl;
   localparam int COLS = 16;
   localparam int AW   = 8;

   typedef struct {
      logic [COLS-1:0]    en;
      logic [COLS*AW-1:0] addr;
   } rd_t;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic                 stagger_load = 1'b0;
   logic [3:0]           num_row = '0;
   logic [3:0]           num_col = '0;
   logic [AW-1:0]        base_addr = '0;
   logic [COLS-1:0]      weightMem_rd_en;
   logic [COLS*AW-1:0]   weightMem_rd_addr;
   logic                 fifo_active;
   logic [COLS-1:0]      fifo_en;
   logic                 done;

   int  checks = 0;
   int  errors = 0;
   rd_t rd_q[$];

   weight_fifo_fill_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .stagger_load      (stagger_load),
      .num_row           (num_row),
      .num_col           (num_col),
      .base_addr         (base_addr),
      .weightMem_rd_en   (weightMem_rd_en),
      .weightMem_rd_addr (weightMem_rd_addr),
      .fifo_active       (fifo_active),
      .fifo_en           (fifo_en),
      .done              (done)
   );

   always #5 clk = ~clk;

   // Every read the DUT issues must match the oldest expected read
   always @(negedge clk) begin
      if (weightMem_rd_en !== '0) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: rd_en=%h addr=%h, required no read", weightMem_rd_en, weightMem_rd_addr);
         end else begin
            rd_t t;
            t = rd_q.pop_front();
            if (weightMem_rd_en !== t.en || weightMem_rd_addr !== t.addr) begin
               errors++;
               $display("FAIL read: rd_en=%h addr=%h, required rd_en=%h addr=%h",
                        weightMem_rd_en, weightMem_rd_addr, t.en, t.addr);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (weightMem_rd_en !== '0 || weightMem_rd_addr !== '0 || fifo_active !== 1'b0 ||
          fifo_en !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rd_en=%h addr=%h act=%b fifo_en=%h done=%b, required all 0",
                  weightMem_rd_en, weightMem_rd_addr, fifo_active, fifo_en, done);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Runs one fill from a negedge; returns at the negedge of cycle done+1 (or rst_cyc+4)
   task automatic do_fill(input int nr, input int nc, input int base, input bit stag,
                          input bit poke, input int rst_cyc);
      int              d, last, lo, hi;
      bit              live, ea, ed;
      logic [COLS-1:0] ee, mask;
      logic [31:0]     m32;
      rd_t             t;
      d    = stag ? nr + COLS + 2 : nr + 3;
      m32  = (32'h1 << (nc + 1)) - 32'h1;
      mask = m32[COLS-1:0];
      for (int k = 0; k <= nr; k++) begin
         if (rst_cyc == 0 || k < rst_cyc) begin
            t.en   = mask;
            t.addr = '0;
            for (int c = 0; c <= nc; c++) t.addr[c*AW +: AW] = AW'(base + k);
            rd_q.push_back(t);
         end
      end
      num_row      = 4'(nr);
      num_col      = 4'(nc);
      base_addr    = AW'(base);
      stagger_load = stag;
      start        = 1'b1;
      @(posedge clk);
      last = (rst_cyc > 0) ? rst_cyc + 4 : d + 1;
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start        = 1'b0;
            num_row      = 4'($urandom);
            num_col      = 4'($urandom);
            base_addr    = AW'($urandom);
            stagger_load = 1'($urandom);
         end
         if (poke && (n == 6 || n == d + 1)) start = 1'b0;
         if (rst_cyc > 0 && n == rst_cyc + 1) reset = 1'b0;
         live = (rst_cyc == 0 || n <= rst_cyc);
         ea   = live && n >= 2 && n <= nr + 2;
         ed   = live && n == d;
         for (int c = 0; c < COLS; c++) begin
            lo    = 2 + (stag ? c : 0);
            hi    = nr + 2 + (stag ? c : 0);
            ee[c] = live && n >= lo && n <= hi;
         end
         checks += 3;
         if (fifo_active !== ea) begin
            errors++;
            $display("FAIL fifo_active cyc%0d: got %b, required %b", n, fifo_active, ea);
         end
         if (fifo_en !== ee) begin
            errors++;
            $display("FAIL fifo_en cyc%0d: got %h, required %h", n, fifo_en, ee);
         end
         if (done !== ed) begin
            errors++;
            $display("FAIL done cyc%0d: got %b, required %b", n, done, ed);
         end
         if (rst_cyc > 0 && n == rst_cyc + 1) begin
            checks++;
            if (weightMem_rd_en !== '0 || weightMem_rd_addr !== '0) begin
               errors++;
               $display("FAIL reset_mid_fill: rd_en=%h addr=%h, required 0", weightMem_rd_en, weightMem_rd_addr);
            end
         end
         if (rst_cyc > 0 && n == rst_cyc) reset = 1'b1;
         if (poke && (n == 5 || n == d)) start = 1'b1;
      end
      checks++;
      if (rd_q.size() != 0) begin
         errors++;
         $display("FAIL read_count: %0d reads outstanding, required 0", rd_q.size());
         rd_q.delete();
      end
   endtask

   task automatic test_full_no_stagger();
      do_fill(15, 15, 12, 1'b0, 1'b0, 0);
   endtask

   task automatic test_full_stagger();
      do_fill(15, 15, 12, 1'b1, 1'b0, 0);
   endtask

   task automatic test_single_row();
      do_fill(0, 3, 8'hFF, 1'b0, 1'b0, 0);
   endtask

   task automatic test_addr_wrap();
      do_fill(1, 7, 8'hFF, 1'b1, 1'b0, 0);
   endtask

   task automatic test_ignored_start();
      do_fill(4, 5, 100, 1'b0, 1'b1, 0);
      do_fill(6, 0, 33, 1'b1, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      do_fill(3, 2, 40, 1'b1, 1'b0, 0);
      do_fill(2, 15, 250, 1'b0, 1'b0, 0);
      do_fill(0, 0, 7, 1'b1, 1'b0, 0);
   endtask

   task automatic test_reset_mid_fill();
      do_fill(15, 15, 20, 1'b1, 1'b0, 6);
      do_fill(7, 9, 3, 1'b1, 1'b0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         do_fill(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), 1'($urandom), 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_full_no_stagger();
      test_full_stagger();
      test_single_row();
      test_addr_wrap();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_fill();
      test_random();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/weight_fifo_fill_ctrl.md
Name: weight_fifo_fill_ctrl

Overview:
- Sequences one weight-tile load from the column-banked weight memory into the per-column weight FIFOs that feed the systolic array.
- On `start`, reads rows `0..num_row` at `base_addr+row` from banks `0..num_col`.
- Enables the FIFOs as the read data returns, either all together or staggered by column.
- Pulses `done` when the last FIFO write completes.

Parameters:
- SYS_ARR_ROWS, 16, systolic array rows; row index width RW = $clog2(SYS_ARR_ROWS).
- SYS_ARR_COLS, 16, systolic array columns, which equals the number of memory banks and FIFOs; column index width CW = $clog2(SYS_ARR_COLS).
- ADDR_WIDTH, 8, weight-memory bank address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a fill; sampled only when idle.
- stagger_load  in  1  0 = all FIFOs enabled together; 1 = column c enabled c cycles late. Sampled with start.
- num_row  in  RW  rows to load minus 1; 15 means 16 rows. Sampled with start.
- num_col  in  CW  active columns minus 1. Sampled with start.
- base_addr  in  ADDR_WIDTH  first row address. Sampled with start.
- weightMem_rd_en  out  SYS_ARR_COLS  per-bank read enable.
- weightMem_rd_addr  out  SYS_ARR_COLS*ADDR_WIDTH  per-bank address; bank c uses bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- fifo_active  out  1  read data valid this cycle, i.e. rd_en activity delayed by 1 cycle.
- fifo_en  out  SYS_ARR_COLS  per-column FIFO write enable.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: synchronous, and also applies mid-operation.
  - All outputs go to 0, the FSM returns to IDLE, and no done is issued.
  - The stagger shift register is cleared.
- Outputs are registered, except fifo_en, which is a combinational decode of registered stagger state.
- Timing convention: start is high and sampled at edge 0; "cycle n" is the period after edge n.
- FSM states: IDLE -> READ -> DRAIN -> IDLE.
- IDLE:
  - On start, latch num_row, num_col, base_addr and stagger_load.
  - Clear the row counter k, then go to READ.
- READ (cycles 1..num_row+1, with k = n-1):
  - rd_en[c] = 1 for c <= num_col; 0 otherwise.
  - rd_addr[c] = base_addr + k, truncated mod 2^ADDR_WIDTH (wrap allowed) for active columns; 0 for inactive columns.
  - When k == num_row, go to DRAIN.
- fifo_active is high in cycles 2..num_row+2, one cycle after each read.
- fifo_en with stagger_load = 0:
  - All SYS_ARR_COLS bits equal fifo_active, in cycles 2..num_row+2.
  - The bank mask does not gate fifo_en.
- fifo_en with stagger_load = 1:
  - Bit c is fifo_active delayed c cycles, i.e. high in cycles 2+c..num_row+2+c.
  - Implement as a SYS_ARR_COLS-deep shift register.
- DRAIN: wait until every fifo_en bit is low and the shift register is empty.
- done timing: pulses for exactly one cycle, then the FSM returns to IDLE.
  - stagger = 0: in cycle num_row+3.
  - stagger = 1: in cycle num_row+SYS_ARR_COLS+2.
- busy = state != IDLE. start while busy is ignored, as is start asserted in the done cycle.
- The next start is accepted the cycle after done. Back-to-back fills are allowed.
- Input changes after sampling have no effect on the fill in progress.
- num_row = 0 gives a single read and a single fifo_en cycle.
- num_col = 0 gives bank 0 only.

Decomposition:
- Shared package holds:
  - RW/CW width localparams derived via $clog2;
  - the FSM state enum (IDLE/READ/DRAIN);
  - the memory read latency constant RD_LAT = 1.
- Natural sub-module: weight_fifo_en_gen.
  - Inputs: clk, reset, active, stagger_load.
  - Outputs: fifo_en, drained/done.
  - Contains the stagger shift register and end-of-fill detection.
- The top holds the FSM, row counter, address generation and the bank mask.

Test Plan:
- Default parameters, num_row=15, num_col=15, base_addr=12, stagger=0, start in one cycle:
  - rd_en=16'hFFFF in cycles 1..16, with rd_addr all banks = 12..27;
  - fifo_active and fifo_en=16'hFFFF in cycles 2..17;
  - done in cycle 18 only.
- Same with stagger=1:
  - fifo_en[0] high in cycles 2..17, fifo_en[15] high in cycles 17..32;
  - done in cycle 33.
- num_row=0, num_col=3, base_addr=8'hFF:
  - a single read with rd_en=16'h000F and addr 8'hFF on banks 0..3 (other banks' addr 0);
  - wrap check: num_row=1 with base 8'hFF reads 8'hFF then 8'h00.
- start pulsed again in cycle 5 of a fill and in the done cycle: ignored, with no extra reads.
- A start the cycle after done: a new fill begins, with rd_en in the next cycle.
- reset asserted in cycle 6 of a fill: in the next cycle all outputs are 0, with no done; a subsequent start runs a full normal fill.
